systolic_array_param: RTL

Parametrised N×N output-stationary systolic matrix-multiply engine, successor to the fixed power-of-two tiled arrays. It computes C = A·B for one tile:
- A is N×K and B is K×N.
- Inputs are signed DATA_W-bit.
- Accumulators are ACC_W-bit.

The block adds internal input skewing, valid/ready streaming of operands, a control FSM, and a row-by-row requantized drain with rounding and saturation. It sits between the operand buffers and the activation write-back path of the accelerator.

---
 rtl/systolic_pkg.sv | 48 ++++
 rtl/systolic_pe.sv | 50 +++++
 rtl/systolic_array_param.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the parametrised output-stationary systolic array:
// default geometry, FSM state encoding and the requantize/saturate helper.
package systolic_pkg;

    localparam int DEF_N      = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;

    // Working width of the requant datapath; holds any ACC_W up to 63 plus
    // the rounding carry without overflow.
    localparam int RQ_W = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FEED  = ST_FEED,
        S_FLUSH = ST_FLUSH,
        S_DRAIN = ST_DRAIN
    } state_t;

    // Round-half-up arithmetic right shift, then clamp to a signed dw-bit range.
    function automatic logic signed [RQ_W-1:0] requant_sat(
        input logic signed [RQ_W-1:0] acc,
        input logic [4:0]             sh,
        input int unsigned            dw
    );
        logic signed [RQ_W-1:0] rnd;
        logic signed [RQ_W-1:0] y;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        rnd = (sh == 5'd0) ? 64'sd0 : (64'sd1 <<< (sh - 5'd1));
        y   = (acc + rnd) >>> sh;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        if (y > hi) begin
            return hi;
        end else if (y < lo) begin
            return lo;
        end else begin
            return y;
        end
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a to the right and b downward through
// registers and accumulates the signed product in place.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic [DATA_W-1:0]          r_a;
    logic [DATA_W-1:0]          r_b;
    logic [ACC_W-1:0]           r_acc;
    logic signed [2*DATA_W-1:0] w_prod;

    assign w_prod = signed'(i_a) * signed'(i_b);

    // Operand pass registers and wrapping multiply-accumulate
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= r_acc + ACC_W'(w_prod);
        end else begin
            r_a   <= r_a;
            r_b   <= r_b;
            r_acc <= r_acc;
        end
    end

    assign o_a   = r_a;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_param.sv
// N x N output-stationary systolic matmul tile: input skew, operand
// streaming, control FSM and a row-by-row requantized drain.
module systolic_array_param
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                  CLOCK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           k_len,
    input  logic [4:0]            shift,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic [N*DATA_W-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DATA_W-1:0]   out_data,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_last,
    output logic                  busy
);

    localparam int ROW_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int FL_W  = $clog2(2 * N);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_k_len;
    logic [15:0]         r_beat_cnt;
    logic [4:0]          r_shift;
    logic [FL_W-1:0]     r_flush_cnt;
    logic [CNT_W-1:0]    r_load_cnt;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_out_valid;
    logic                r_out_last;
    logic [N*DATA_W-1:0] r_out_data;
    logic [ROW_W-1:0]    r_out_row;

    logic                w_start;
    logic                w_accept;
    logic                w_adv;
    logic                w_load;
    logic                w_last_take;
    logic [ROW_W-1:0]    w_row_sel;
    logic [N*ACC_W-1:0]  w_sel_acc;
    logic [N*DATA_W-1:0] w_rq_row;

    logic [DATA_W-1:0]   w_a_inj [N];
    logic [DATA_W-1:0]   w_b_inj [N];
    logic [DATA_W-1:0]   w_a_sk  [N];
    logic [DATA_W-1:0]   w_b_sk  [N];
    logic [DATA_W-1:0]   w_ah    [N][N+1];
    logic [DATA_W-1:0]   w_bv    [N+1][N];
    logic [ACC_W-1:0]    w_acc   [N][N];

    assign w_start     = (r_state == S_IDLE) && start;
    assign w_accept    = (r_state == S_FEED) && r_in_ready && in_valid;
    assign w_adv       = (r_state == S_FEED) || (r_state == S_FLUSH);
    assign w_load      = (r_state == S_DRAIN) && (r_load_cnt < CNT_W'(N)) &&
                         (!r_out_valid || out_ready);
    assign w_last_take = r_out_valid && out_ready && r_out_last;
    assign w_row_sel   = r_load_cnt[ROW_W-1:0];

    // State register
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (k_len == 16'd0) ? S_FLUSH : S_FEED;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FEED: begin
                if (w_accept && ((r_beat_cnt + 16'd1) == r_k_len)) begin
                    w_next = S_FLUSH;
                end else begin
                    w_next = S_FEED;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == FL_W'(2 * N - 2)) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (w_last_take) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Tile parameters, beat/flush/drain counters and registered status
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_k_len     <= 16'd0;
            r_shift     <= 5'd0;
            r_beat_cnt  <= 16'd0;
            r_load_cnt  <= '0;
            r_flush_cnt <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_start) begin
                r_k_len    <= k_len;
                r_shift    <= shift;
                r_beat_cnt <= 16'd0;
                r_load_cnt <= '0;
            end else begin
                r_beat_cnt <= w_accept ? r_beat_cnt + 16'd1 : r_beat_cnt;
                r_load_cnt <= w_load ? r_load_cnt + CNT_W'(1) : r_load_cnt;
            end
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + FL_W'(1) : '0;
            r_in_ready  <= (w_next == S_FEED);
            r_busy      <= (w_next != S_IDLE);
        end
    end

    // Per-lane operand injection (zeros on bubbles) and input skew
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_a_inj[gi] = w_accept ? in_a[gi*DATA_W +: DATA_W] : '0;
        assign w_b_inj[gi] = w_accept ? in_b[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_nodly
            assign w_a_sk[gi] = w_a_inj[gi];
            assign w_b_sk[gi] = w_b_inj[gi];
        end else begin : g_dly
            logic [DATA_W-1:0] r_a_d [gi];
            logic [DATA_W-1:0] r_b_d [gi];
            // Delay line holding lane gi back by gi array advances
            always_ff @(posedge CLOCK or posedge reset) begin
                if (reset || w_start) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_d[s] <= '0;
                        r_b_d[s] <= '0;
                    end
                end else if (w_adv) begin
                    r_a_d[0] <= w_a_inj[gi];
                    r_b_d[0] <= w_b_inj[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_a_d[s] <= r_a_d[s-1];
                        r_b_d[s] <= r_b_d[s-1];
                    end
                end else begin
                    r_a_d <= r_a_d;
                    r_b_d <= r_b_d;
                end
            end
            assign w_a_sk[gi] = r_a_d[gi-1];
            assign w_b_sk[gi] = r_b_d[gi-1];
        end
        assign w_ah[gi][0] = w_a_sk[gi];
        assign w_bv[0][gi] = w_b_sk[gi];
    end

    // PE grid: a flows right along rows, b flows down columns
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .CLOCK (CLOCK),
                .reset (reset),
                .i_clr (w_start),
                .i_en  (w_adv),
                .i_a   (w_ah[gi][gj]),
                .i_b   (w_bv[gi][gj]),
                .o_a   (w_ah[gi][gj+1]),
                .o_b   (w_bv[gi+1][gj]),
                .o_acc (w_acc[gi][gj])
            );
        end
    end

    // Drain mux: select the accumulator row currently being emitted
    always_comb begin
        w_sel_acc = '0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                w_sel_acc[j*ACC_W +: ACC_W] = w_sel_acc[j*ACC_W +: ACC_W] |
                    ((w_row_sel == ROW_W'(r)) ? w_acc[r][j] : '0);
            end
        end
    end

    // Requantize every lane of the selected row
    always_comb begin
        w_rq_row = '0;
        for (int j = 0; j < N; j++) begin
            w_rq_row[j*DATA_W +: DATA_W] = DATA_W'(requant_sat(
                RQ_W'(signed'(w_sel_acc[j*ACC_W +: ACC_W])), r_shift, DATA_W));
        end
    end

    // Output row register: load on free slot, hold under backpressure
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rq_row;
            r_out_row   <= w_row_sel;
            r_out_last  <= (w_row_sel == ROW_W'(N - 1));
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign out_last  = r_out_last;

endmodule
